pattern_timer_ctrl: RTL and testbench
=====================================

Name: pattern_timer_ctrl

Overview:
Complete sequencer for the serial-triggered delay timer. It scans a serial input for a start pattern, then enables the shifter for DELAY_W cycles to capture a delay value MSB-first. It then runs a down-counter for (delay+1)*UNIT_CYCLES clock cycles and holds done until the user acknowledges. It owns the one-hot control FSM, the delay shift register and the unit/cycle counters, replacing hand-wired next-state glue.

Parameters:
DELAY_W, 4, width of the captured delay field and of the count output (>=2)
UNIT_CYCLES, 1000, clock cycles per delay unit (>=2)
PATTERN, 4'b1101, start pattern, first bit received = MSB, fixed length 4

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; forces search state and clears all registers
data  input  1  serial input; pattern and delay bits, sampled each clk
ack  input  1  user acknowledge; only honoured in WAIT
count  output  DELAY_W  remaining whole units; equals delay register contents
counting  output  1  high in COUNT state
done  output  1  high in WAIT state
shift_ena  output  1  high in the DELAY_W shift states

Behaviour:
- Reset (sync, active-high): state=S (search, nothing matched), delay reg=0, unit counter=UNIT_CYCLES-1; count=0, counting=0, done=0, shift_ena=0. Reset mid-operation wins over every transition, in any state.
- States (one-hot register): S, S1, S11, S110 (pattern prefix matched), B0..B(DELAY_W-1) (shift), COUNT, WAIT. Outputs are pure functions of the current state and registers (Moore). No output depends combinationally on data or ack.
- Search, overlapping, for PATTERN=1101: S: 1->S1, 0->S. S1: 1->S11, 0->S. S11: 1->S11, 0->S110. S110: 1->B0, 0->S. Generic PATTERN uses the equivalent KMP fallback.
- Shift: in each Bk, shift_ena=1 and delay <= {delay[DELAY_W-2:0], data}. Bk advances to B(k+1); the last B advances to COUNT. shift_ena is high for exactly DELAY_W consecutive cycles, starting the cycle after the final pattern bit.
- COUNT: unit counter counts down from UNIT_CYCLES-1 each cycle.
  - When unit counter==0 and delay!=0: delay decrements and the unit counter reloads to UNIT_CYCLES-1.
  - When unit counter==0 and delay==0: next state is WAIT.
  - counting is high for exactly (D+1)*UNIT_CYCLES cycles, where D is the captured delay.
  - count shows D for the first UNIT_CYCLES cycles, then D-1, down to 0.
- Unit counter width is clog2(UNIT_CYCLES). The delay register never underflows. D = 2^DELAY_W-1 is legal.
- WAIT: done=1 and count=0. ack=1 moves to S (search restarts fresh; bits before the ack cycle are not reused). ack=0 stays in WAIT.
- data is ignored outside search and shift states. ack is ignored outside WAIT, including when held high during COUNT. ack high on the first WAIT cycle exits after exactly one done cycle.
- Entering COUNT reloads the unit counter to UNIT_CYCLES-1. Entering S clears the delay register.

Test Plan:
- Reset then data 1,1,0,1 then 0,1,0,1 -> shift_ena high 4 cycles, delay=5; counting high exactly 6000 cycles; count 5,4,3,2,1,0 stepping every 1000 cycles; done high the cycle after counting falls.
- Pattern then delay 0000 -> counting high exactly 1000 cycles with count=0; done asserted next cycle and held 50 cycles while ack=0; ack=1 for one cycle -> done low next cycle, state S.
- Overlap stream 1,1,1,0,1 then 0,0,1,0 -> trigger on 5th bit, delay=2, 3000 counting cycles. Stream 1,1,0,0,1,1,0,1 -> no trigger until the 8th bit.
- ack held high throughout a delay-1 run -> no early exit; counting lasts 2000 cycles; done high exactly 1 cycle. Data toggling during COUNT -> no effect on count or timing.
- reset pulsed at COUNT cycle 1234 of a delay-3 run -> next cycle all outputs 0; subsequent 1101+0001 run -> 2000 counting cycles.
- Delay 1111 with UNIT_CYCLES=2 override -> counting high exactly 32 cycles; count decrements every 2 cycles from 15 to 0.

Source files
------------

// File: rtl/pattern_timer_ctrl_if.sv
// pattern_timer_ctrl_if: serial data/ack inputs and timer status outputs of the pattern timer
interface pattern_timer_ctrl_if #(parameter int DELAY_W = 4);
  logic data;
  logic ack;
  logic [DELAY_W-1:0] count;
  logic counting;
  logic done;
  logic shift_ena;
  modport master(output data, ack, input count, counting, done, shift_ena);
  modport slave(input data, ack, output count, counting, done, shift_ena);
endinterface

// File: rtl/pattern_timer_ctrl.sv
// pattern_timer_ctrl: serial start-pattern search, delay capture, unit down-counter and ack handshake
module pattern_timer_ctrl #(
  parameter int DELAY_W = 4,
  parameter int UNIT_CYCLES = 1000,
  parameter logic [3:0] PATTERN = 4'b1101
) (
  input logic clk,
  input logic reset,
  pattern_timer_ctrl_if.slave bus
);
  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int BW = $clog2(DELAY_W);
  localparam logic [UW-1:0] UNIT_MAX = UW'(UNIT_CYCLES - 1);
  typedef enum logic [6:0] {
    S = 7'b0000001, M1 = 7'b0000010, M2 = 7'b0000100, M3 = 7'b0001000,
    SHIFT = 7'b0010000, COUNT = 7'b0100000, WAIT = 7'b1000000
  } state_t;
  state_t state, state_next;
  logic [DELAY_W-1:0] delay;
  logic [UW-1:0] unit;
  logic [BW-1:0] bidx;
  int mlen, nxt;
  // pattern bit i in reception order (0 = first received)
  function automatic logic pat(input int i);
    logic [3:0] t;
    t = PATTERN >> (3 - i);
    return t[0];
  endfunction
  // longest suffix of (matched prefix + new bit) that is again a pattern prefix
  function automatic int kmp(input int m, input logic b);
    int n;
    logic ok;
    logic rb;
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      ok = k <= m + 1;
      for (int j = 0; j < 4; j++)
        if (ok && j < k) begin
          rb = (m + 1 - k + j == m) ? b : pat(m + 1 - k + j);
          ok = rb == pat(j);
        end
      if (ok) n = k;
    end
    return n;
  endfunction
  // next-state logic; the shift phase is one state stepped through DELAY_W times by bidx
  always_comb begin
    mlen = state == M1 ? 1 : state == M2 ? 2 : state == M3 ? 3 : 0;
    nxt = kmp(mlen, bus.data);
    state_next = state;
    if (state inside {S, M1, M2, M3})
      state_next = nxt == 4 ? SHIFT : nxt == 3 ? M3 : nxt == 2 ? M2 : nxt == 1 ? M1 : S;
    else if (state == SHIFT && bidx == BW'(DELAY_W - 1))
      state_next = COUNT;
    else if (state == COUNT && unit == '0 && delay == '0)
      state_next = WAIT;
    else if (state == WAIT && bus.ack)
      state_next = S;
  end
  // state, delay shift/decrement, unit counter reload and shift index
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S;
      delay <= '0;
      unit <= UNIT_MAX;
      bidx <= '0;
    end else begin
      state <= state_next;
      delay <= state == SHIFT ? {delay[DELAY_W-2:0], bus.data}
             : (state == COUNT && unit == '0 && delay != '0) ? delay - 1'b1
             : state_next == S ? '0 : delay;
      unit <= (state == COUNT && unit != '0) ? unit - 1'b1 : UNIT_MAX;
      bidx <= state == SHIFT ? bidx + 1'b1 : '0;
    end
  end
  assign bus.count = delay;
  assign bus.counting = state == COUNT;
  assign bus.done = state == WAIT;
  assign bus.shift_ena = state == SHIFT;
endmodule

// File: tb/tb_pattern_timer_ctrl.sv
// tb_pattern_timer_ctrl: directed checks of pattern search, delay capture, timing and ack
module tb_pattern_timer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int sh = 0;
  pattern_timer_ctrl_if #(.DELAY_W(4)) a ();
  pattern_timer_ctrl_if #(.DELAY_W(4)) b ();
  pattern_timer_ctrl #(.DELAY_W(4), .UNIT_CYCLES(1000), .PATTERN(4'b1101)) u0 (.clk(clk), .reset(reset), .bus(a.slave));
  pattern_timer_ctrl #(.DELAY_W(4), .UNIT_CYCLES(2), .PATTERN(4'b1101)) u1 (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] bits, input int n);
    logic [7:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) begin
      a.data = v[i];
      if (a.shift_ena) sh++;
      tick();
    end
    a.data = 1'b0;
  endtask
  task automatic run(input string tag, input int d, input int u, input int len, input logic toggle);
    int n;
    int err;
    n = 0;
    err = 0;
    while (a.counting && n < 40000) begin
      if (int'(a.count) != d - n / u) err++;
      if (toggle) a.data = ~a.data;
      tick();
      n++;
    end
    check({tag, "_len"}, n, len);
    check({tag, "_cnt"}, err, 0);
    check({tag, "_done"}, int'(a.done), 1);
    check({tag, "_count0"}, int'(a.count), 0);
  endtask
  task automatic leave();
    a.ack = 1'b1;
    tick();
    a.ack = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int err;
    a.data = 1'b0;
    a.ack = 1'b0;
    b.data = 1'b0;
    b.ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_count", int'(a.count), 0);
    check("rst_counting", int'(a.counting), 0);
    check("rst_done", int'(a.done), 0);
    check("rst_shift", int'(a.shift_ena), 0);
    send(8'b1101, 4);
    check("p1_shift_on", int'(a.shift_ena), 1);
    sh = 0;
    send(8'b0101, 4);
    check("p1_shift_len", sh, 4);
    check("p1_count_d", int'(a.count), 5);
    run("d5", 5, 1000, 6000, 1'b0);
    leave();
    check("d5_ack", int'(a.done), 0);
    send(8'b11010000, 8);
    run("d0", 0, 1000, 1000, 1'b0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (a.done) n++;
      tick();
    end
    check("d0_hold", n, 50);
    leave();
    check("d0_ack_done", int'(a.done), 0);
    check("d0_ack_counting", int'(a.counting), 0);
    send(8'b1110, 4);
    check("ovl_no_trig", int'(a.shift_ena), 0);
    send(8'b1, 1);
    check("ovl_trig", int'(a.shift_ena), 1);
    send(8'b0010, 4);
    run("d2", 2, 1000, 3000, 1'b0);
    leave();
    send(8'b1100110, 7);
    check("miss7", int'(a.shift_ena), 0);
    send(8'b1, 1);
    check("hit8", int'(a.shift_ena), 1);
    a.ack = 1'b1;
    send(8'b0001, 4);
    run("d1ack", 1, 1000, 2000, 1'b1);
    tick();
    check("d1ack_exit", int'(a.done), 0);
    a.ack = 1'b0;
    a.data = 1'b0;
    tick();
    send(8'b11010011, 8);
    for (int i = 0; i < 1234; i++) tick();
    check("d3_mid_counting", int'(a.counting), 1);
    check("d3_mid_count", int'(a.count), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_count", int'(a.count), 0);
    check("mrst_counting", int'(a.counting), 0);
    check("mrst_done", int'(a.done), 0);
    check("mrst_shift", int'(a.shift_ena), 0);
    send(8'b11010001, 8);
    run("post_rst", 1, 1000, 2000, 1'b0);
    leave();
    for (int i = 7; i >= 0; i--) begin
      b.data = (8'b11011111 >> i) & 8'd1;
      tick();
    end
    b.data = 1'b0;
    n = 0;
    err = 0;
    while (b.counting && n < 1000) begin
      if (int'(b.count) != 15 - n / 2) err++;
      tick();
      n++;
    end
    check("u2_len", n, 32);
    check("u2_cnt", err, 0);
    check("u2_done", int'(b.done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
